// File: rtl/systolic_pkg.sv
// systolic_pkg: default dimensions, widths and signed element types for the input-stationary array
package systolic_pkg;
   localparam int DEF_INPUT_WIDTH = 16;
   localparam int DEF_WEIGHT_WIDTH = 16;
   localparam int DEF_PSUM_WIDTH = 32;
   localparam int DEF_ARRAY_HEIGHT = 4;
   localparam int DEF_ARRAY_WIDTH = 4;
   typedef logic signed [DEF_INPUT_WIDTH-1:0] input_t;
   typedef logic signed [DEF_WEIGHT_WIDTH-1:0] weight_t;
   typedef logic signed [DEF_PSUM_WIDTH-1:0] psum_t;
endpackage

// File: rtl/systolic_pe_is.sv
// systolic_pe_is: holds one stationary X element, registers the passing weight, psum_out = psum_in + x*w
module systolic_pe_is
   import systolic_pkg::*;
#(
   parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
   parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
   parameter int PSUM_WIDTH = DEF_PSUM_WIDTH
) (
   input logic clk,
   input logic rst_n,
   input logic load,
   input logic en,
   input logic signed [INPUT_WIDTH-1:0] x_in,
   output logic signed [INPUT_WIDTH-1:0] x_out,
   input logic signed [WEIGHT_WIDTH-1:0] w_in,
   output logic signed [WEIGHT_WIDTH-1:0] w_out,
   input logic signed [PSUM_WIDTH-1:0] psum_in,
   output logic signed [PSUM_WIDTH-1:0] psum_out
);
   logic signed [INPUT_WIDTH+WEIGHT_WIDTH-1:0] prod;
   always_ff @(posedge clk)
      if (!rst_n) begin
         x_out <= '0;
         w_out <= '0;
      end else begin
         if (load) x_out <= x_in;
         if (en) w_out <= w_in;
      end
   assign prod = (INPUT_WIDTH+WEIGHT_WIDTH)'(x_out) * (INPUT_WIDTH+WEIGHT_WIDTH)'(w_in);
   assign psum_out = psum_in + PSUM_WIDTH'(prod);
endmodule

// File: rtl/systolic_array_is.sv
// systolic_array_is: input-stationary signed systolic matrix multiply, Y = X*W' one row per advancing cycle
module systolic_array_is
   import systolic_pkg::*;
#(
   parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
   parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
   parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
   parameter int ARRAY_HEIGHT = DEF_ARRAY_HEIGHT,
   parameter int ARRAY_WIDTH = DEF_ARRAY_WIDTH
) (
   input logic clk,
   input logic rst_n,
   input logic input_en,
   input logic process_en,
   input logic signed [INPUT_WIDTH-1:0] input_in [ARRAY_HEIGHT],
   input logic signed [WEIGHT_WIDTH-1:0] weight_in [ARRAY_WIDTH],
   output logic signed [PSUM_WIDTH-1:0] psum_out [ARRAY_WIDTH]
);
   localparam int H = ARRAY_HEIGHT;
   localparam int W = ARRAY_WIDTH;
   localparam int KW = H > 1 ? $clog2(H) : 1;
   localparam int RD = H + W - 3;
   localparam int VL = H + 2*W - 3;
   logic [KW-1:0] k;
   logic [VL-1:0] vld;
   logic signed [INPUT_WIDTH-1:0] xv [H][W+1];
   logic signed [WEIGHT_WIDTH-1:0] wv [H][W+1];
   logic signed [PSUM_WIDTH-1:0] pin [H][W];
   logic signed [PSUM_WIDTH-1:0] pc [H][W];
   logic signed [PSUM_WIDTH-1:0] pr [H-1][W];
   logic signed [PSUM_WIDTH-1:0] dsk [W][W-1];
   logic signed [PSUM_WIDTH-1:0] cat [W][W];
   logic signed [PSUM_WIDTH-1:0] nxt [W];
   for (genvar r = 0; r < H; r++) begin : g_row
      logic signed [WEIGHT_WIDTH-1:0] sr [W];
      logic signed [WEIGHT_WIDTH-1:0] src [W];
      always_comb
         for (int i = 0; i < W; i++) src[i] = (k == KW'(r)) ? weight_in[i] : sr[i];
      always_ff @(posedge clk)
         if (!rst_n) sr <= '{default: '0};
         else if (process_en) begin
            sr[0] <= '0;
            for (int i = 1; i < W; i++) sr[i] <= src[i-1];
         end
      assign wv[r][0] = src[W-1];
      assign xv[r][W] = input_in[r];
      for (genvar j = 0; j < W; j++) begin : g_col
         systolic_pe_is #(
            .INPUT_WIDTH(INPUT_WIDTH),
            .WEIGHT_WIDTH(WEIGHT_WIDTH),
            .PSUM_WIDTH(PSUM_WIDTH)
         ) u_pe (
            .clk(clk),
            .rst_n(rst_n),
            .load(input_en),
            .en(process_en),
            .x_in(xv[r][j+1]),
            .x_out(xv[r][j]),
            .w_in(wv[r][j]),
            .w_out(wv[r][j+1]),
            .psum_in(pin[r][j]),
            .psum_out(pc[r][j])
         );
      end
   end
   always_comb begin
      for (int j = 0; j < W; j++) begin
         pin[0][j] = '0;
         for (int r = 1; r < H; r++) pin[r][j] = pr[r-1][j];
         cat[j][0] = pc[H-1][j];
         for (int i = 1; i < W; i++) cat[j][i] = dsk[j][i-1];
      end
      for (int c = 0; c < W; c++) nxt[c] = '0;
      for (int j = 0; j < W; j++)
         if (vld[RD+j])
            for (int c = 0; c < W; c++) nxt[c] = cat[j][W-1-c];
   end
   always_ff @(posedge clk)
      if (!rst_n) begin
         k <= '0;
         vld <= '0;
         pr <= '{default: '0};
         dsk <= '{default: '0};
         psum_out <= '{default: '0};
      end else if (process_en) begin
         k <= (k == KW'(H-1)) ? '0 : k + KW'(1);
         vld <= {vld[VL-2:0], k == '0};
         for (int r = 0; r < H-1; r++)
            for (int j = 0; j < W; j++) pr[r][j] <= pc[r][j];
         for (int j = 0; j < W; j++)
            for (int i = 0; i < W-1; i++) dsk[j][i] <= cat[j][i];
         psum_out <= nxt;
      end
endmodule

// File: tb/tb_systolic_array_is.sv
// tb_systolic_array_is: directed table-driven and sequence checks of the input-stationary systolic array
module tb_systolic_array_is;
   import systolic_pkg::*;
   typedef struct {
      string name;
      logic [0:3][0:3][15:0] x;
      logic [0:3][0:3][15:0] w;
      logic [0:3][0:3][31:0] y;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n;
   logic input_en;
   logic process_en;
   input_t input_in [4];
   weight_t weight_in [4];
   psum_t psum_out [4];
   vec_t tv [7];
   int nchk = 0;
   int nerr = 0;
   systolic_array_is u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .input_en(input_en),
      .process_en(process_en),
      .input_in(input_in),
      .weight_in(weight_in),
      .psum_out(psum_out)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input int a, input int lane, input int act, input int exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s edge=%0d lane=%0d: got %0d expected %0d", nm, a, lane, act, exp);
      end
   endtask
   task automatic load_x(input int v, input bit extra);
      input_en = 1'b1;
      if (extra) begin
         for (int r = 0; r < 4; r++) input_in[r] = 16'sd99;
         tick();
      end
      for (int j = 0; j < 4; j++) begin
         for (int r = 0; r < 4; r++) input_in[r] = tv[v].x[j][r];
         tick();
      end
      input_en = 1'b0;
   endtask
   task automatic run_pass(input int v, input int np, input int st, input int sl, input string nm);
      int e [4];
      int prev [4];
      prev = '{0, 0, 0, 0};
      for (int a = 0; a < 4*(np+2); a++) begin
         if (a == st) begin
            process_en = 1'b0;
            for (int m = 0; m < 4; m++) weight_in[m] = 16'sd555;
            for (int s = 0; s < sl; s++) begin
               tick();
               for (int c = 0; c < 4; c++) chk({nm, "_hold"}, a, c, int'(psum_out[c]), prev[c]);
            end
         end
         process_en = 1'b1;
         for (int m = 0; m < 4; m++)
            weight_in[m] = (a < 4*np) ? 16'(int'($signed(tv[v].w[a%4][m])) * (a/4+1)) : 16'sd0;
         tick();
         for (int c = 0; c < 4; c++) begin
            e[c] = (a >= 6 && a < 6+4*np) ? int'($signed(tv[v].y[(a-6)%4][c])) * ((a-6)/4+1) : 0;
            chk(nm, a, c, int'(psum_out[c]), e[c]);
         end
         prev = e;
      end
      process_en = 1'b0;
   endtask
   initial begin
      tv[0].name = "basic";
      tv[0].x = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16};
      tv[0].w = {16'd4, 16'd3, 16'd2, 16'd1, 16'd8, 16'd7, 16'd6, 16'd5, 16'd12, 16'd11, 16'd10, 16'd9, 16'd16, 16'd15, 16'd14, 16'd13};
      tv[0].y = {32'd90, 32'd100, 32'd110, 32'd120, 32'd202, 32'd228, 32'd254, 32'd280, 32'd314, 32'd356, 32'd398, 32'd440, 32'd426, 32'd484, 32'd542, 32'd600};
      tv[1].name = "identity";
      tv[1].x = {16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
      tv[1].w = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16};
      tv[1].y = {32'd4, 32'd3, 32'd2, 32'd1, 32'd8, 32'd7, 32'd6, 32'd5, 32'd12, 32'd11, 32'd10, 32'd9, 32'd16, 32'd15, 32'd14, 32'd13};
      tv[2].name = "mixed_sign";
      tv[2].x = {16{16'd1}};
      tv[2].w = {4{16'd1, 16'hFFFE, 16'd3, 16'hFFFC}};
      tv[2].y = {4{32'hFFFFFFF0, 32'd12, 32'hFFFFFFF8, 32'd4}};
      tv[3].name = "min_min_wrap";
      tv[3].x = {16{16'h8000}};
      tv[3].w = {16{16'h8000}};
      tv[3].y = '0;
      tv[4].name = "neg1_x_2";
      tv[4].x = {16{16'hFFFF}};
      tv[4].w = {16{16'd2}};
      tv[4].y = {16{32'hFFFFFFF8}};
      tv[5].name = "max_max_wrap";
      tv[5].x = {16{16'h7FFF}};
      tv[5].w = {16{16'h7FFF}};
      tv[5].y = {16{32'hFFFC0004}};
      tv[6].name = "min_max";
      tv[6].x = {16{16'h8000}};
      tv[6].w = {16{16'h7FFF}};
      tv[6].y = {16{32'h00020000}};
      rst_n = 1'b0;
      input_en = 1'b0;
      process_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         input_in[i] = '0;
         weight_in[i] = '0;
      end
      tick();
      tick();
      for (int c = 0; c < 4; c++) chk("reset", -1, c, int'(psum_out[c]), 0);
      rst_n = 1'b1;
      for (int v = 0; v < 7; v++) begin
         load_x(v, 1'b0);
         run_pass(v, 1, -1, 0, tv[v].name);
      end
      load_x(0, 1'b0);
      run_pass(0, 1, 2, 3, "stall_mid");
      run_pass(0, 1, 7, 3, "stall_out");
      process_en = 1'b1;
      for (int a = 0; a < 7; a++) begin
         for (int m = 0; m < 4; m++) weight_in[m] = (a < 4) ? tv[0].w[a][m] : 16'sd0;
         tick();
      end
      for (int c = 0; c < 4; c++) chk("pre_reset_row0", 6, c, int'(psum_out[c]), int'($signed(tv[0].y[0][c])));
      rst_n = 1'b0;
      tick();
      for (int c = 0; c < 4; c++) chk("mid_reset", -1, c, int'(psum_out[c]), 0);
      rst_n = 1'b1;
      process_en = 1'b0;
      load_x(0, 1'b0);
      run_pass(0, 1, -1, 0, "after_reset");
      run_pass(0, 2, -1, 0, "back_to_back");
      load_x(0, 1'b1);
      run_pass(0, 1, -1, 0, "five_loads");
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
